// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the five-stage MIPS pipeline. Looks at
//   the IF_ID / ID_EX / EX_MEM boundaries and drives PC and pipeline-register
//   write enables, bubbles and flushes. Handles load-use stalls, taken-branch
//   flushes (memory-stage PCSrc) and multi-cycle data-memory waits with a
//   watchdog.
//
//   Build option: define HAZARD_PERF_CNT_EN to build the stall/flush
//   performance counters. Without it both counters read constant 0.
//
// Parameters
//   CNT_W     width of each performance counter
//   WAIT_MAX  max consecutive MEM_WAIT cycles before the watchdog fires (1..255)
//
// Ports
//   clk, reset        clock (rising edge), async active-low reset
//   id_rs, id_rt      source fields of the instruction in IF_ID
//   id_uses_rt        IF_ID instruction reads rt
//   ex_mem_read       MemRead of the instruction in ID_EX
//   ex_rt             load destination held in ID_EX
//   mem_pcsrc         branch taken (memory stage)
//   dmem_busy         data memory not ready
//   pc_write, if_id_write, id_ex_bubble, stage_hold        hold/bubble controls
//   if_id_flush, id_ex_flush, ex_mem_flush                  flush controls
//   timeout_err       sticky watchdog flag
//   stall_cnt, flush_cnt  saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_pcsrc,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             stage_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, FLUSH} state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       timeout_q;
    logic       load_use;
    logic       wd_expire;

    // Register 0 is never a real load destination, so it never stalls.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // The last permitted wait edge with memory still busy: busy is ignored
    // here so the pipeline is released rather than hanging forever.
    assign wd_expire = (state_q == MEM_WAIT) && (wait_q == 8'(WAIT_MAX - 1)) && dmem_busy;

    always_comb begin
        state_d = RUN;
        if (mem_pcsrc)
            state_d = FLUSH;
        else if (dmem_busy && !wd_expire)
            state_d = MEM_WAIT;
        else if (load_use)
            state_d = LU_STALL;

        // Counter only survives an edge that stays in MEM_WAIT; any exit
        // (including a branch) clears it.
        wait_d = 8'd0;
        if (state_q == MEM_WAIT && state_d == MEM_WAIT)
            wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (wd_expire)
                timeout_q <= 1'b1;
        end
    end

    // Moore decode of the control outputs.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b0;
        stage_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        unique case (state_q)
            RUN: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
            LU_STALL: id_ex_bubble = 1'b1;
            MEM_WAIT: stage_hold   = 1'b1;
            FLUSH: begin
                pc_write     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign timeout_err = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((state_q == LU_STALL || state_q == MEM_WAIT) && stall_q != {CNT_W{1'b1}})
                stall_q <= stall_q + CNT_W'(1);
            if (state_d == FLUSH && flush_q != {CNT_W{1'b1}})
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed scenarios followed by randomized traffic, all compared every cycle
//   against a behavioural model of the stall/flush rules. Small parameters
//   (CNT_W=4, WAIT_MAX=4) make watchdog and saturation reachable quickly.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, mem_pcsrc, dmem_busy;
    logic             pc_write, if_id_write, id_ex_bubble, stage_hold;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, timeout_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_pcsrc(mem_pcsrc), .dmem_busy(dmem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .stage_hold(stage_hold),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .timeout_err(timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: what the pipeline is doing this cycle.
    string m_mode;
    int    m_wait;     // consecutive busy cycles already spent waiting
    bit    m_to;
    int    m_stall, m_flush;
    localparam int SAT = (1 << CNT_W) - 1;

    function automatic void model_reset();
        m_mode = "run"; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
    endfunction

    function automatic void model_step(bit pcsrc, bit busy, bit emr, int ert,
                                       int rs, int rt, bit urt);
        bit    hz     = emr && ert != 0 && (ert == rs || (urt && ert == rt));
        bit    expire = (m_mode == "wait") && busy && (m_wait + 1 == WAIT_MAX);
        string nxt;
        if (expire) m_to = 1;
        if (m_mode == "stall" || m_mode == "wait") m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        if (pcsrc)                nxt = "flush";
        else if (busy && !expire) nxt = "wait";
        else if (hz)              nxt = "stall";
        else                      nxt = "run";
        if (nxt == "flush") m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        m_wait = (m_mode == "wait" && nxt == "wait") ? m_wait + 1 : 0;
        m_mode = nxt;
    endfunction

    // {pc_write, if_id_write, id_ex_bubble, stage_hold, if_id_flush, id_ex_flush, ex_mem_flush}
    function automatic logic [6:0] model_outs();
        case (m_mode)
            "run":   return 7'b1100000;
            "stall": return 7'b0010000;
            "wait":  return 7'b0001000;
            default: return 7'b1000111;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_ctl"}, 32'({pc_write, if_id_write, id_ex_bubble, stage_hold,
                                if_id_flush, id_ex_flush, ex_mem_flush}), 32'(model_outs()));
        chk({tag, "_to"},    32'(timeout_err), 32'(m_to));
        chk({tag, "_stall"}, 32'(stall_cnt),   PERF ? 32'(m_stall) : 32'd0);
        chk({tag, "_flush"}, 32'(flush_cnt),   PERF ? 32'(m_flush) : 32'd0);
    endtask

    // Called at a falling edge: apply inputs, let one rising edge pass, check.
    task automatic cyc(input string tag, input bit pcsrc, input bit busy, input bit emr,
                       input int ert, input int rs, input int rt, input bit urt);
        mem_pcsrc   = pcsrc;  dmem_busy = busy; ex_mem_read = emr;
        ex_rt       = 5'(ert); id_rs    = 5'(rs); id_rt     = 5'(rt);
        id_uses_rt  = urt;
        model_step(pcsrc, busy, emr, ert, rs, rt, urt);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1 check_all({tag, "_async"});
        @(negedge clk); check_all({tag, "_held"});
        @(negedge clk); check_all({tag, "_held2"});
        reset = 1'b1;
    endtask

    int cnt;
    int busy_left;

    initial begin
        reset = 1'b0; mem_pcsrc = 0; dmem_busy = 0; ex_mem_read = 0;
        ex_rt = '0; id_rs = '0; id_rt = '0; id_uses_rt = 0;
        model_reset();
        @(negedge clk); check_all("rst0");
        @(negedge clk); check_all("rst1");
        reset = 1'b1;
        idle("post_rst");
        chk("rst_pcw", 32'(pc_write), 32'd1);

        // Load-use: exactly one stall cycle.
        cnt = 0;
        cyc("lu", 0, 0, 1, 9, 9, 3, 0); if (!pc_write) cnt++;
        chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
        idle("lu_a"); if (!pc_write) cnt++;
        idle("lu_b"); if (!pc_write) cnt++;
        chk("lu_len", 32'(cnt), 32'd1);

        // Same pattern with $zero destination: no stall.
        cnt = 0;
        cyc("lu0", 0, 0, 1, 0, 0, 0, 1); if (!pc_write) cnt++;
        idle("lu0_a"); if (!pc_write) cnt++;
        chk("lu0_len", 32'(cnt), 32'd0);

        // rt match only counts when the instruction reads rt.
        cyc("lurt_no", 0, 0, 1, 7, 2, 7, 0);
        chk("lurt_no_pcw", 32'(pc_write), 32'd1);
        cyc("lurt_yes", 0, 0, 1, 7, 2, 7, 1);
        chk("lurt_yes_pcw", 32'(pc_write), 32'd0);
        idle("lurt_end");

        // Branch: one-cycle flush.
        cyc("br", 1, 0, 0, 0, 0, 0, 0);
        chk("br_fl", 32'({if_id_flush, id_ex_flush, ex_mem_flush, pc_write}), 32'hF);
        idle("br_end");

        // Three-cycle branch pulse gives three flush cycles.
        for (int i = 0; i < 3; i++) cyc("br3", 1, 0, 0, 0, 0, 0, 0);
        idle("br3_end");

        // Priority: branch beats memory wait and load-use.
        cyc("prio", 1, 1, 1, 5, 5, 5, 1);
        chk("prio_fl", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'd7);
        chk("prio_hold", 32'(stage_hold), 32'd0);
        idle("prio_end");

        // Watchdog: busy held, WAIT_MAX hold cycles then timeout.
        cnt = 0;
        for (int i = 0; i < WAIT_MAX + 1; i++) begin
            cyc("wd", 0, 1, 0, 0, 0, 0, 0);
            if (stage_hold) cnt++;
        end
        chk("wd_len", 32'(cnt), 32'(WAIT_MAX));
        chk("wd_to", 32'(timeout_err), 32'd1);
        chk("wd_pcw", 32'(pc_write), 32'd1);
        for (int i = 0; i < 3; i++) idle("wd_sticky");

        // Branch in the middle of a memory wait.
        cyc("mwb0", 0, 1, 0, 0, 0, 0, 0);
        cyc("mwb1", 0, 1, 0, 0, 0, 0, 0);
        cyc("mwb2", 1, 1, 0, 0, 0, 0, 0);
        cyc("mwb3", 0, 1, 0, 0, 0, 0, 0);
        idle("mwb_end");

        // Asynchronous reset in the middle of a wait clears everything.
        cyc("mid", 0, 1, 0, 0, 0, 0, 0);
        dmem_busy = 0;
        #2 do_reset("midrst");
        idle("midrst_end");

        // Saturation: 20 load-use events.
        for (int i = 0; i < 20; i++) begin
            cyc("sat_lu", 0, 0, 1, 9, 9, 0, 0);
            idle("sat_idle");
        end
        chk("sat_val", 32'(stall_cnt), PERF ? 32'd15 : 32'd0);

        // Randomized traffic.
        do_reset("rnd_rst");
        busy_left = 0;
        for (int i = 0; i < 3000; i++) begin
            bit b;
            if (busy_left == 0 && $urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 7);
            b = (busy_left != 0);
            if (busy_left != 0) busy_left--;
            cyc("rnd", $urandom_range(0, 11) == 0, b, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            if (i == 1500) begin
                #2 do_reset("rnd_mid");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
